// File: rtl/ray_hit_resolver_if.sv
// Stream bundle between the sphere tracer, the hit resolver and the frame-buffer writer.
interface ray_hit_resolver_if #(
  parameter int OBJ_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [9:0]       t_in;
  logic [11:0]      color_in;
  logic             out_valid;
  logic             out_ready;
  logic [11:0]      out_color;
  logic [9:0]       out_t;
  logic [OBJ_W-1:0] out_obj;
  logic             out_hit;
  logic [9:0]       out_x;
  logic [8:0]       out_y;
  logic             frame_done;

  modport master (
    output in_valid, t_in, color_in, out_ready,
    input  in_ready, out_valid, out_color, out_t, out_obj, out_hit, out_x, out_y, frame_done
  );

  modport slave (
    input  in_valid, t_in, color_in, out_ready,
    output in_ready, out_valid, out_color, out_t, out_obj, out_hit, out_x, out_y, frame_done
  );
endinterface

// File: rtl/ray_hit_resolver.sv
// Nearest-hit resolver: folds N_OBJ hit distances per pixel into one coloured pixel,
// emitted through a single valid/ready register stage with its raster address.
module ray_hit_resolver #(
  parameter int          N_OBJ    = 4,
  parameter int          OBJ_W    = 2,
  parameter int          H_RES    = 640,
  parameter int          V_RES    = 480,
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter logic [9:0]  MISS_T   = 10'h3FF
) (
  input logic              clk,
  input logic              rst,
  ray_hit_resolver_if.slave bus_if
);

  logic [9:0]       best_t_q, best_t_d;
  logic [11:0]      best_color_q, best_color_d;
  logic [OBJ_W-1:0] best_obj_q, best_obj_d;
  logic [OBJ_W-1:0] obj_cnt_q, obj_cnt_d;

  logic             out_valid_q, out_valid_d;
  logic [11:0]      out_color_q, out_color_d;
  logic [9:0]       out_t_q, out_t_d;
  logic [OBJ_W-1:0] out_obj_q, out_obj_d;
  logic             out_hit_q, out_hit_d;
  logic [9:0]       x_q, x_d;
  logic [8:0]       y_q, y_d;
  logic             frame_done_q, frame_done_d;

  logic             in_ready;
  logic             accept;
  logic             out_fire;
  logic             last_obj;
  logic             take;
  logic [9:0]       cand_t;
  logic [11:0]      cand_color;
  logic [OBJ_W-1:0] cand_obj;
  logic             cand_hit;

  assign in_ready = ~out_valid_q | bus_if.out_ready;
  assign accept   = bus_if.in_valid & in_ready;
  assign out_fire = out_valid_q & bus_if.out_ready;
  assign last_obj = (obj_cnt_q == OBJ_W'(N_OBJ - 1));

  // Strict compare keeps the earlier object on ties; a miss code never displaces anything.
  assign take       = (bus_if.t_in != MISS_T) && (bus_if.t_in < best_t_q);
  assign cand_t     = take ? bus_if.t_in : best_t_q;
  assign cand_color = take ? bus_if.color_in : best_color_q;
  assign cand_obj   = take ? obj_cnt_q : best_obj_q;
  assign cand_hit   = (cand_t != MISS_T);

  always_comb begin
    best_t_d     = best_t_q;
    best_color_d = best_color_q;
    best_obj_d   = best_obj_q;
    obj_cnt_d    = obj_cnt_q;
    out_valid_d  = out_valid_q;
    out_color_d  = out_color_q;
    out_t_d      = out_t_q;
    out_obj_d    = out_obj_q;
    out_hit_d    = out_hit_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;

    if (out_fire) begin
      out_valid_d = 1'b0;
      if (x_q == 10'(H_RES - 1)) begin
        x_d = '0;
        y_d = (y_q == 9'(V_RES - 1)) ? '0 : y_q + 9'd1;
        frame_done_d = (y_q == 9'(V_RES - 1));
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    if (accept) begin
      if (last_obj) begin
        out_valid_d  = 1'b1;
        out_t_d      = cand_t;
        out_hit_d    = cand_hit;
        out_color_d  = cand_hit ? cand_color : BG_COLOR;
        out_obj_d    = cand_hit ? cand_obj : '0;
        best_t_d     = MISS_T;
        best_color_d = BG_COLOR;
        best_obj_d   = '0;
        obj_cnt_d    = '0;
      end else begin
        best_t_d     = cand_t;
        best_color_d = cand_color;
        best_obj_d   = cand_obj;
        obj_cnt_d    = obj_cnt_q + OBJ_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_t_q     <= MISS_T;
      best_color_q <= BG_COLOR;
      best_obj_q   <= '0;
      obj_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      out_color_q  <= '0;
      out_t_q      <= MISS_T;
      out_obj_q    <= '0;
      out_hit_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      best_t_q     <= best_t_d;
      best_color_q <= best_color_d;
      best_obj_q   <= best_obj_d;
      obj_cnt_q    <= obj_cnt_d;
      out_valid_q  <= out_valid_d;
      out_color_q  <= out_color_d;
      out_t_q      <= out_t_d;
      out_obj_q    <= out_obj_d;
      out_hit_q    <= out_hit_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus_if.in_ready   = in_ready;
  assign bus_if.out_valid  = out_valid_q;
  assign bus_if.out_color  = out_color_q;
  assign bus_if.out_t      = out_t_q;
  assign bus_if.out_obj    = out_obj_q;
  assign bus_if.out_hit    = out_hit_q;
  assign bus_if.out_x      = x_q;
  assign bus_if.out_y      = y_q;
  assign bus_if.frame_done = frame_done_q;

endmodule

// File: tb/tb_ray_hit_resolver.sv
// Bench for ray_hit_resolver: table vectors, hand-built corner sequences and a random
// stream scored against a queue-based pixel model.
module tb_ray_hit_resolver;

  localparam int          N_OBJ = 4;
  localparam int          OBJ_W = 2;
  localparam int          H     = 4;
  localparam int          V     = 3;
  localparam logic [11:0] BG    = 12'h5A5;
  localparam logic [9:0]  MISS  = 10'h3FF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ray_hit_resolver_if #(.OBJ_W(OBJ_W)) bus ();

  ray_hit_resolver #(
    .N_OBJ(N_OBJ), .OBJ_W(OBJ_W), .H_RES(H), .V_RES(V), .BG_COLOR(BG), .MISS_T(MISS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_if(bus)
  );

  typedef struct packed {
    logic [9:0]       t;
    logic [11:0]      c;
    logic [OBJ_W-1:0] o;
    logic             h;
    logic [9:0]       x;
    logic [8:0]       y;
  } pix_t;

  typedef struct {
    logic [3:0][9:0]  t;
    logic [3:0][11:0] c;
    logic [9:0]       et;
    logic [11:0]      ec;
    logic [1:0]       eo;
    logic             eh;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  logic [9:0]  pend_t[$];
  logic [11:0] pend_c[$];
  pix_t        exp_q[$];
  int          push_cnt = 0;
  logic        exp_fd = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Nearest = smallest distance; the owner is the first object reporting it.
  function automatic pix_t resolve();
    pix_t p;
    p.t = MISS;
    foreach (pend_t[i]) if (pend_t[i] < p.t) p.t = pend_t[i];
    p.h = (p.t != MISS);
    p.o = '0;
    p.c = BG;
    if (p.h) begin
      for (int i = N_OBJ - 1; i >= 0; i--) begin
        if (pend_t[i] == p.t) begin
          p.o = OBJ_W'(i);
          p.c = pend_c[i];
        end
      end
    end
    p.x = 10'(push_cnt % H);
    p.y = 9'((push_cnt / H) % V);
    push_cnt++;
    return p;
  endfunction

  task automatic check_outputs();
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0)
      chk("pixel", {bus.out_t, bus.out_color, bus.out_obj, bus.out_hit, bus.out_x, bus.out_y}, exp_q[0]);
    chk("frame_done", {63'd0, bus.frame_done}, {63'd0, exp_fd});
  endtask

  // One clock: drive inputs, predict the edge, then compare the registered outputs.
  task automatic cyc(input logic iv, input logic [9:0] t, input logic [11:0] c, input logic ordy);
    logic exp_rdy;
    bus.in_valid  = iv;
    bus.t_in      = t;
    bus.color_in  = c;
    bus.out_ready = ordy;
    #1;
    exp_rdy = (exp_q.size() == 0) || ordy;
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
    exp_fd = 1'b0;
    if (exp_q.size() != 0 && ordy) begin
      exp_fd = (exp_q[0].x == 10'(H - 1)) && (exp_q[0].y == 9'(V - 1));
      void'(exp_q.pop_front());
    end
    if (iv && exp_rdy) begin
      pend_t.push_back(t);
      pend_c.push_back(c);
      if (pend_t.size() == N_OBJ) begin
        exp_q.push_back(resolve());
        pend_t.delete();
        pend_c.delete();
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_color", {52'd0, bus.out_color}, 64'd0);
    chk("rst_t", {54'd0, bus.out_t}, {54'd0, MISS});
    chk("rst_obj", {62'd0, bus.out_obj}, 64'd0);
    chk("rst_hit", {63'd0, bus.out_hit}, 64'd0);
    chk("rst_xy", {45'd0, bus.out_x, bus.out_y}, 64'd0);
    chk("rst_fd", {63'd0, bus.frame_done}, 64'd0);
    pend_t.delete();
    pend_c.delete();
    exp_q.delete();
    push_cnt = 0;
    exp_fd = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [9:0] rand_t();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return MISS;
    if (r < 5) return 10'($urandom_range(0, 7));
    return 10'($urandom_range(0, 1022));
  endfunction

  vec_t vecs[6];
  int   fd_cnt;

  initial begin
    bus.in_valid = 1'b0; bus.t_in = '0; bus.color_in = '0; bus.out_ready = 1'b0;

    vecs[0].t = {MISS, 10'd500, 10'd120, 10'd300};
    vecs[0].c = {12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA};
    vecs[0].et = 10'd120; vecs[0].ec = 12'hBBB; vecs[0].eo = 2'd1; vecs[0].eh = 1'b1;
    vecs[1].t = {MISS, MISS, MISS, MISS};
    vecs[1].c = {12'h444, 12'h333, 12'h222, 12'h111};
    vecs[1].et = MISS; vecs[1].ec = BG; vecs[1].eo = 2'd0; vecs[1].eh = 1'b0;
    vecs[2].t = {10'd900, 10'd700, 10'd200, 10'd200};
    vecs[2].c = {12'h444, 12'h333, 12'h222, 12'h111};
    vecs[2].et = 10'd200; vecs[2].ec = 12'h111; vecs[2].eo = 2'd0; vecs[2].eh = 1'b1;
    vecs[3].t = {10'd5, 10'd700, 10'd800, 10'd900};
    vecs[3].c = {12'h0F0, 12'h00F, 12'hF00, 12'h123};
    vecs[3].et = 10'd5; vecs[3].ec = 12'h0F0; vecs[3].eo = 2'd3; vecs[3].eh = 1'b1;
    vecs[4].t = {10'h3FE, MISS, 10'h3FE, 10'd0};
    vecs[4].c = {12'h999, 12'h888, 12'h777, 12'h666};
    vecs[4].et = 10'd0; vecs[4].ec = 12'h666; vecs[4].eo = 2'd0; vecs[4].eh = 1'b1;
    vecs[5].t = {MISS, MISS, 10'h3FE, MISS};
    vecs[5].c = {12'hEEE, 12'hABC, 12'hFED, 12'h321};
    vecs[5].et = 10'h3FE; vecs[5].ec = 12'hFED; vecs[5].eo = 2'd1; vecs[5].eh = 1'b1;

    @(posedge clk);
    #1;
    do_reset();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N_OBJ; i++) cyc(1'b1, vecs[v].t[i], vecs[v].c[i], 1'b1);
      chk("vec_t", {54'd0, bus.out_t}, {54'd0, vecs[v].et});
      chk("vec_color", {52'd0, bus.out_color}, {52'd0, vecs[v].ec});
      chk("vec_obj", {62'd0, bus.out_obj}, {62'd0, vecs[v].eo});
      chk("vec_hit", {63'd0, bus.out_hit}, {63'd0, vecs[v].eh});
    end

    // Back-pressure: completed pixel must hold and block the low-t inputs offered meanwhile.
    cyc(1'b1, 10'd40, 12'h101, 1'b1);
    cyc(1'b1, 10'd30, 12'h202, 1'b1);
    cyc(1'b1, 10'd50, 12'h303, 1'b1);
    cyc(1'b1, 10'd60, 12'h404, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 10'd1, 12'hBAD, 1'b0);
      chk("stall_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("stall_t", {54'd0, bus.out_t}, 64'd30);
    end
    cyc(1'b1, 10'd70, 12'h111, 1'b1);
    cyc(1'b1, 10'd80, 12'h222, 1'b1);
    cyc(1'b1, 10'd90, 12'h333, 1'b1);
    cyc(1'b1, 10'd75, 12'h444, 1'b1);
    chk("after_stall_t", {54'd0, bus.out_t}, 64'd70);
    chk("after_stall_c", {52'd0, bus.out_color}, 64'h111);

    // Reset in the middle of a pixel discards the partial minimum.
    cyc(1'b1, 10'd5, 12'hF0F, 1'b1);
    cyc(1'b1, 10'd6, 12'hF1F, 1'b1);
    do_reset();
    cyc(1'b1, 10'd250, 12'h0A0, 1'b1);
    cyc(1'b1, 10'd90, 12'h0B0, 1'b1);
    cyc(1'b1, 10'd700, 12'h0C0, 1'b1);
    cyc(1'b1, 10'd90, 12'h0D0, 1'b1);
    chk("post_rst_t", {54'd0, bus.out_t}, 64'd90);
    chk("post_rst_obj", {62'd0, bus.out_obj}, 64'd1);
    chk("post_rst_xy", {45'd0, bus.out_x, bus.out_y}, 64'd0);

    // Full frame of H*V pixels plus one to observe the wrap.
    do_reset();
    fd_cnt = 0;
    for (int p = 0; p < (H * V + 1) * N_OBJ; p++) begin
      cyc(1'b1, rand_t(), 12'($urandom), 1'b1);
      fd_cnt += int'(bus.frame_done);
    end
    chk("wrap_xy", {45'd0, bus.out_x, bus.out_y}, 64'd0);
    cyc(1'b0, 10'd0, 12'd0, 1'b1);
    fd_cnt += int'(bus.frame_done);
    chk("fd_count", 64'(fd_cnt), 64'd1);

    for (int n = 0; n < 2000; n++)
      cyc($urandom_range(0, 3) != 0, rand_t(), 12'($urandom), $urandom_range(0, 9) < 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
